// File: rtl/page_load_scheduler_if.sv
// -----------------------------------------------------------------------------
// page_load_scheduler_if
// Command bus between the page-load scheduler and the SPI flash loader.
//   loader_start      : one-cycle command pulse (scheduler -> loader)
//   loader_bootloader : command type, 1 = bootloader image (held start..done)
//   loader_page       : page number to transfer (held start..done)
//   loader_image      : image number to transfer (held start..done)
//   loader_done       : one-cycle completion pulse (loader -> scheduler)
// Modports: master = scheduler side, slave = SPI loader side.
// -----------------------------------------------------------------------------
interface page_load_scheduler_if #(
   parameter int PAGE_WIDTH  = 12,
   parameter int IMAGE_WIDTH = 3
);
   logic                   loader_start;
   logic                   loader_bootloader;
   logic [PAGE_WIDTH-1:0]  loader_page;
   logic [IMAGE_WIDTH-1:0] loader_image;
   logic                   loader_done;

   modport master (
      output loader_start,
      output loader_bootloader,
      output loader_page,
      output loader_image,
      input  loader_done
   );

   modport slave (
      input  loader_start,
      input  loader_bootloader,
      input  loader_page,
      input  loader_image,
      output loader_done
   );
endinterface

// File: rtl/page_load_scheduler.sv
// -----------------------------------------------------------------------------
// page_load_scheduler
// Sequences flash-to-buffer transfers for the bubble emulator. Page and
// bootloader requests are held in one-deep pending slots; the bootloader slot
// wins arbitration, but a running load is never preempted. One command at a
// time goes to the SPI loader, which fills the hidden bank of a ping-pong
// buffer pair; a completed load swaps the banks. A watchdog aborts loads
// whose loader_done never arrives.
// Ports:
//   master_clock, reset          : clock, synchronous active-high reset
//   image_number                 : image select, captured when a command issues
//   page_request, page_number    : page load request pulse + page
//   bootloader_request           : bootloader load request pulse
//   ldr (master)                 : command bus to the SPI loader
//   write_bank / read_bank       : loader bank / interface bank (complements)
//   ready, ready_page,
//   ready_is_bootloader          : description of the data in read_bank
//   request_dropped              : pulse when a pending page request is replaced
//   timeout_error                : sticky watchdog abort flag
// TIMEOUT_CYCLES must lie in 1..65535 (16-bit watchdog timer).
// -----------------------------------------------------------------------------
module page_load_scheduler #(
   parameter int PAGE_WIDTH     = 12,
   parameter int IMAGE_WIDTH    = 3,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   master_clock,
   input  logic                   reset,
   input  logic [IMAGE_WIDTH-1:0] image_number,
   input  logic                   page_request,
   input  logic [PAGE_WIDTH-1:0]  page_number,
   input  logic                   bootloader_request,
   page_load_scheduler_if.master  ldr,
   output logic                   write_bank,
   output logic                   read_bank,
   output logic                   ready,
   output logic [PAGE_WIDTH-1:0]  ready_page,
   output logic                   ready_is_bootloader,
   output logic                   request_dropped,
   output logic                   timeout_error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_SWAP  = 2'd3
   } state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [15:0]            timer_q, timer_d;
   logic                   pend_boot_q, pend_boot_d;
   logic                   pend_page_q, pend_page_d;
   logic [PAGE_WIDTH-1:0]  pend_page_num_q, pend_page_num_d;
   logic                   cmd_boot_q, cmd_boot_d;
   logic [PAGE_WIDTH-1:0]  cmd_page_q, cmd_page_d;
   logic [IMAGE_WIDTH-1:0] cmd_image_q, cmd_image_d;
   logic                   read_bank_q, read_bank_d;
   logic                   ready_q, ready_d;
   logic [PAGE_WIDTH-1:0]  ready_page_q, ready_page_d;
   logic                   ready_boot_q, ready_boot_d;
   logic                   dropped_q, dropped_d;
   logic                   timeout_error_q, timeout_error_d;
   logic                   issue_boot, issue_page;

   always_comb begin
      state_d         = state_q;
      timer_d         = timer_q;
      cmd_boot_d      = cmd_boot_q;
      cmd_page_d      = cmd_page_q;
      cmd_image_d     = cmd_image_q;
      read_bank_d     = read_bank_q;
      ready_d         = ready_q;
      ready_page_d    = ready_page_q;
      ready_boot_d    = ready_boot_q;
      timeout_error_d = timeout_error_q;
      issue_boot      = 1'b0;
      issue_page      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pend_boot_q) begin
               issue_boot  = 1'b1;
               cmd_boot_d  = 1'b1;
               cmd_page_d  = '0;
               cmd_image_d = image_number;
               state_d     = ST_START;
            end else if (pend_page_q) begin
               issue_page  = 1'b1;
               cmd_boot_d  = 1'b0;
               cmd_page_d  = pend_page_num_q;
               cmd_image_d = image_number;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done pulse in the final watchdog cycle still counts as success.
            if (ldr.loader_done) begin
               state_d = ST_SWAP;
            end else if (timer_q == TIMER_LAST) begin
               timeout_error_d = 1'b1;
               state_d         = ST_IDLE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_SWAP: begin
            read_bank_d  = ~read_bank_q;
            ready_d      = 1'b1;
            ready_page_d = cmd_page_q;
            ready_boot_d = cmd_boot_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A new request wins over the slot being consumed in the same cycle, so
      // nothing is lost; replacing a slot that is being issued is not a drop.
      pend_boot_d     = bootloader_request | (pend_boot_q & ~issue_boot);
      pend_page_d     = page_request | (pend_page_q & ~issue_page);
      pend_page_num_d = page_request ? page_number : pend_page_num_q;
      dropped_d       = page_request & pend_page_q & ~issue_page;
   end

   always_ff @(posedge master_clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         timer_q         <= '0;
         pend_boot_q     <= 1'b0;
         pend_page_q     <= 1'b0;
         pend_page_num_q <= '0;
         cmd_boot_q      <= 1'b0;
         cmd_page_q      <= '0;
         cmd_image_q     <= '0;
         read_bank_q     <= 1'b0;
         ready_q         <= 1'b0;
         ready_page_q    <= '0;
         ready_boot_q    <= 1'b0;
         dropped_q       <= 1'b0;
         timeout_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         pend_boot_q     <= pend_boot_d;
         pend_page_q     <= pend_page_d;
         pend_page_num_q <= pend_page_num_d;
         cmd_boot_q      <= cmd_boot_d;
         cmd_page_q      <= cmd_page_d;
         cmd_image_q     <= cmd_image_d;
         read_bank_q     <= read_bank_d;
         ready_q         <= ready_d;
         ready_page_q    <= ready_page_d;
         ready_boot_q    <= ready_boot_d;
         dropped_q       <= dropped_d;
         timeout_error_q <= timeout_error_d;
      end
   end

   assign ldr.loader_start      = (state_q == ST_START);
   assign ldr.loader_bootloader = cmd_boot_q;
   assign ldr.loader_page       = cmd_page_q;
   assign ldr.loader_image      = cmd_image_q;
   assign read_bank             = read_bank_q;
   assign write_bank            = ~read_bank_q;
   assign ready                 = ready_q;
   assign ready_page            = ready_page_q;
   assign ready_is_bootloader   = ready_boot_q;
   assign request_dropped       = dropped_q;
   assign timeout_error         = timeout_error_q;

endmodule

// File: tb/tb_page_load_scheduler.sv
// -----------------------------------------------------------------------------
// tb_page_load_scheduler
// Directed bench for page_load_scheduler. dut0 uses the default watchdog,
// dut1 uses TIMEOUT_CYCLES = 8; both share all stimulus. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_page_load_scheduler;
   localparam int PW = 12;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] image_number;
   logic          page_request;
   logic [PW-1:0] page_number;
   logic          bootloader_request;
   logic          loader_done;

   logic          wb0, rb0, rdy0, rib0, drop0, te0;
   logic [PW-1:0] rp0;
   logic          wb1, rb1, rdy1, rib1, drop1, te1;
   logic [PW-1:0] rp1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [34:0] got;
   logic [34:0] exp_v;

   always #5 clk = ~clk;

   page_load_scheduler_if #(.PAGE_WIDTH(PW), .IMAGE_WIDTH(IW)) bus0 ();
   page_load_scheduler_if #(.PAGE_WIDTH(PW), .IMAGE_WIDTH(IW)) bus1 ();
   assign bus0.loader_done = loader_done;
   assign bus1.loader_done = loader_done;

   page_load_scheduler #(.PAGE_WIDTH(PW), .IMAGE_WIDTH(IW)) dut0 (
      .master_clock        (clk),
      .reset               (rst),
      .image_number        (image_number),
      .page_request        (page_request),
      .page_number         (page_number),
      .bootloader_request  (bootloader_request),
      .ldr                 (bus0),
      .write_bank          (wb0),
      .read_bank           (rb0),
      .ready               (rdy0),
      .ready_page          (rp0),
      .ready_is_bootloader (rib0),
      .request_dropped     (drop0),
      .timeout_error       (te0)
   );

   page_load_scheduler #(.PAGE_WIDTH(PW), .IMAGE_WIDTH(IW), .TIMEOUT_CYCLES(8)) dut1 (
      .master_clock        (clk),
      .reset               (rst),
      .image_number        (image_number),
      .page_request        (page_request),
      .page_number         (page_number),
      .bootloader_request  (bootloader_request),
      .ldr                 (bus1),
      .write_bank          (wb1),
      .read_bank           (rb1),
      .ready               (rdy1),
      .ready_page          (rp1),
      .ready_is_bootloader (rib1),
      .request_dropped     (drop1),
      .timeout_error       (te1)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   task automatic pulse_page(input logic [PW-1:0] p);
      page_request = 1'b1;
      page_number  = p;
      step(1);
      page_request = 1'b0;
   endtask

   task automatic pulse_done();
      loader_done = 1'b1;
      step(1);
      loader_done = 1'b0;
   endtask

   // Full observable state of dut0, packed for one-shot comparison.
   function automatic logic [34:0] snap0();
      return {bus0.loader_start, bus0.loader_bootloader, bus0.loader_page, bus0.loader_image,
              wb0, rb0, rdy0, rp0, rib0, drop0, te0};
   endfunction

   task automatic test_reset();
      do_reset();
      got   = snap0();
      exp_v = {1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL reset_values: got %h expected %h", got, exp_v);
      end
      $display("test_reset: complete");
   endtask

   task automatic test_single_page();
      image_number = 3'd6;
      pulse_page(12'h123);
      step(1);
      n_cmp++;
      if ({bus0.loader_start, bus0.loader_bootloader, bus0.loader_page, bus0.loader_image} !== {1'b1, 1'b0, 12'h123, 3'd6}) begin
         n_bad++;
         $display("FAIL single_cmd: got start=%0b boot=%0b page=%h img=%0d expected 1 0 123 6",
                  bus0.loader_start, bus0.loader_bootloader, bus0.loader_page, bus0.loader_image);
      end
      step(1);
      n_cmp++;
      if (bus0.loader_start !== 1'b0) begin
         n_bad++;
         $display("FAIL single_start_width: got %0b expected 0", bus0.loader_start);
      end
      step(18);
      pulse_done();
      n_cmp++;
      if ({rb0, rdy0} !== 2'b00) begin
         n_bad++;
         $display("FAIL single_pre_swap: got rb=%0b rdy=%0b expected 0 0", rb0, rdy0);
      end
      step(1);
      n_cmp++;
      if ({rb0, wb0, rdy0, rp0, rib0} !== {1'b1, 1'b0, 1'b1, 12'h123, 1'b0}) begin
         n_bad++;
         $display("FAIL single_swap: got rb=%0b wb=%0b rdy=%0b page=%h rib=%0b expected 1 0 1 123 0",
                  rb0, wb0, rdy0, rp0, rib0);
      end
      $display("test_single_page: complete");
   endtask

   task automatic test_done_in_idle();
      pulse_done();
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({bus0.loader_start, rb0, rdy0} !== 3'b011) begin
            n_bad++;
            $display("FAIL idle_done_cycle%0d: got start=%0b rb=%0b rdy=%0b expected 0 1 1",
                     i, bus0.loader_start, rb0, rdy0);
         end
         step(1);
      end
      $display("test_done_in_idle: complete");
   endtask

   task automatic test_simultaneous();
      do_reset();
      image_number       = 3'd2;
      page_request       = 1'b1;
      page_number        = 12'h010;
      bootloader_request = 1'b1;
      step(1);
      page_request       = 1'b0;
      bootloader_request = 1'b0;
      step(1);
      n_cmp++;
      if ({bus0.loader_start, bus0.loader_bootloader} !== 2'b11) begin
         n_bad++;
         $display("FAIL sim_first_boot: got start=%0b boot=%0b expected 1 1",
                  bus0.loader_start, bus0.loader_bootloader);
      end
      step(1);
      pulse_done();
      step(1);
      n_cmp++;
      if ({rb0, rdy0, rib0} !== 3'b111) begin
         n_bad++;
         $display("FAIL sim_boot_swap: got rb=%0b rdy=%0b rib=%0b expected 1 1 1", rb0, rdy0, rib0);
      end
      step(1);
      n_cmp++;
      if ({bus0.loader_start, bus0.loader_bootloader, bus0.loader_page} !== {1'b1, 1'b0, 12'h010}) begin
         n_bad++;
         $display("FAIL sim_second_page: got start=%0b boot=%0b page=%h expected 1 0 010",
                  bus0.loader_start, bus0.loader_bootloader, bus0.loader_page);
      end
      step(1);
      pulse_done();
      step(1);
      n_cmp++;
      if ({rb0, wb0, rdy0, rp0, rib0} !== {1'b0, 1'b1, 1'b1, 12'h010, 1'b0}) begin
         n_bad++;
         $display("FAIL sim_page_swap: got rb=%0b wb=%0b rdy=%0b page=%h rib=%0b expected 0 1 1 010 0",
                  rb0, wb0, rdy0, rp0, rib0);
      end
      $display("test_simultaneous: complete");
   endtask

   task automatic test_drop();
      do_reset();
      image_number = 3'd5;
      pulse_page(12'h0AA);
      step(2);
      pulse_page(12'h001);
      n_cmp++;
      if (drop0 !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_first_req: got %0b expected 0", drop0);
      end
      pulse_page(12'h002);
      n_cmp++;
      if (drop0 !== 1'b1) begin
         n_bad++;
         $display("FAIL drop_pulse: got %0b expected 1", drop0);
      end
      step(1);
      n_cmp++;
      if (drop0 !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_one_cycle: got %0b expected 0", drop0);
      end
      pulse_done();
      step(1);
      n_cmp++;
      if ({rb0, rp0} !== {1'b1, 12'h0AA}) begin
         n_bad++;
         $display("FAIL drop_first_swap: got rb=%0b page=%h expected 1 0aa", rb0, rp0);
      end
      step(1);
      n_cmp++;
      if ({bus0.loader_start, bus0.loader_page, bus0.loader_image} !== {1'b1, 12'h002, 3'd5}) begin
         n_bad++;
         $display("FAIL drop_next_cmd: got start=%0b page=%h img=%0d expected 1 002 5",
                  bus0.loader_start, bus0.loader_page, bus0.loader_image);
      end
      $display("test_drop: complete");
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_page(12'h055);
      step(1);
      n_cmp++;
      if (bus1.loader_start !== 1'b1) begin
         n_bad++;
         $display("FAIL to_start: got %0b expected 1", bus1.loader_start);
      end
      step(8);
      n_cmp++;
      if (te1 !== 1'b0) begin
         n_bad++;
         $display("FAIL to_early: got %0b expected 0", te1);
      end
      step(1);
      n_cmp++;
      if ({te1, rb1, wb1, rdy1} !== 4'b1010) begin
         n_bad++;
         $display("FAIL to_abort: got te=%0b rb=%0b wb=%0b rdy=%0b expected 1 0 1 0", te1, rb1, wb1, rdy1);
      end
      pulse_page(12'h066);
      step(1);
      n_cmp++;
      if ({bus1.loader_start, bus1.loader_page, te1} !== {1'b1, 12'h066, 1'b1}) begin
         n_bad++;
         $display("FAIL to_reissue: got start=%0b page=%h te=%0b expected 1 066 1",
                  bus1.loader_start, bus1.loader_page, te1);
      end
      $display("test_timeout: complete");
   endtask

   task automatic test_reset_midload();
      do_reset();
      pulse_page(12'h0F0);
      step(2);
      pulse_page(12'h0F1);
      step(4);
      do_reset();
      pulse_done();
      got   = snap0();
      exp_v = {1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL midload_reset_values: got %h expected %h", got, exp_v);
      end
      for (int i = 0; i < 4; i++) begin
         step(1);
         n_cmp++;
         if ({bus0.loader_start, rb0, rdy0} !== 3'b000) begin
            n_bad++;
            $display("FAIL midload_quiet_cycle%0d: got start=%0b rb=%0b rdy=%0b expected 0 0 0",
                     i, bus0.loader_start, rb0, rdy0);
         end
      end
      $display("test_reset_midload: complete");
   endtask

   initial begin
      rst                = 1'b1;
      image_number       = '0;
      page_request       = 1'b0;
      page_number        = '0;
      bootloader_request = 1'b0;
      loader_done        = 1'b0;
      step(1);
      test_reset();
      test_single_page();
      test_done_in_idle();
      test_simultaneous();
      test_drop();
      test_timeout();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/page_load_scheduler.md
# page_load_scheduler

Sequences all flash-to-buffer transfers for the bubble emulator. It accepts page-load and bootloader-load requests from the bubble interface and arbitrates them, giving the bootloader priority. It issues one load command at a time to the SPI loader and manages a ping-pong pair of bubble buffers: the loader always fills the hidden bank while the interface reads the visible one. A watchdog aborts loads that never complete.

## Interface
- PAGE_WIDTH, 12, width of page number
- IMAGE_WIDTH, 3, width of image number
- TIMEOUT_CYCLES, 65535, max cycles from loader_start to loader_done before abort; counter is 16 bits
- master_clock  in  1  sole clock; everything is synchronous to its rising edge
- reset  in  1  synchronous, active-high
- image_number  in  IMAGE_WIDTH  image select; sampled when a command is issued
- page_request  in  1  one-cycle pulse: load page_number
- page_number  in  PAGE_WIDTH  page to load; valid with page_request
- bootloader_request  in  1  one-cycle pulse: load bootloader
- loader_done  in  1  one-cycle pulse from SPI loader: transfer finished
- loader_start  out  1  one-cycle command pulse to SPI loader
- loader_bootloader  out  1  command type, held from start to done (1 = bootloader)
- loader_page  out  PAGE_WIDTH  command page, held from start to done
- loader_image  out  IMAGE_WIDTH  command image, held from start to done
- write_bank  out  1  bank the loader writes; always ~read_bank
- read_bank  out  1  bank the bubble interface reads
- ready  out  1  read_bank holds valid data
- ready_page  out  PAGE_WIDTH  page held in read_bank
- ready_is_bootloader  out  1  read_bank holds the bootloader
- request_dropped  out  1  one-cycle pulse: a pending page request was overwritten
- timeout_error  out  1  sticky; set on watchdog abort

## Operation
- Reset values: all outputs 0; write_bank = 1; state IDLE; pending flags cleared; timer 0.
- Pending slots, one deep per type: pend_boot, and pend_page with pend_page_num.
  - A request pulse sets its slot in any state.
  - A page_request arriving while pend_page = 1 overwrites pend_page_num and pulses request_dropped.
- States:
  - IDLE: if pend_boot, issue a bootloader command; else if pend_page, issue a page command; else stay. Issuing means: latch the loader_* outputs, clear the chosen slot, go to START.
  - START: loader_start = 1 for this cycle only; timer cleared; go to WAIT.
  - WAIT: timer increments each cycle.
    - On loader_done: go to SWAP.
    - If timer reaches TIMEOUT_CYCLES - 1 without loader_done: set timeout_error, go to IDLE with no swap. Bank contents and ready are unchanged.
  - SWAP: toggle read_bank/write_bank; ready = 1; ready_page = loader_page; ready_is_bootloader = loader_bootloader; go to IDLE.
- Bootloader has strict priority, but a load already in progress is never preempted.
- loader_done is ignored outside WAIT.
- ready stays set once set; it is cleared only by reset.

## Timing
- Request at edge N while IDLE and nothing pending → slot set at N → state START at N+1 → loader_start high during cycle N+1 → WAIT at N+2.
- loader_done sampled at edge M in WAIT → SWAP at M+1 → bank toggle and ready visible after edge M+1.
- Minimum back-to-back gap is 1 IDLE cycle. A request pending on SWAP exit gets loader_start 2 cycles after SWAP.
- Simultaneous page_request and bootloader_request: both slots set; bootloader issued first, page issued next.
- Request in the same cycle as loader_done: the request is pended and served after SWAP.
- Reset mid-load: immediate return to reset values, pending requests lost. A late loader_done after reset is ignored (state is IDLE).
- Timer width is 16 bits; TIMEOUT_CYCLES ≤ 65535 is a parameter constraint.

## Test plan
- Reset, then page_request with page_number = 0x123 → loader_start pulse one cycle later with loader_page = 0x123 and loader_bootloader = 0; loader_done 20 cycles later → 2 cycles after done, read_bank = 1, ready = 1, ready_page = 0x123.
- page_request(0x010) and bootloader_request in the same cycle → first command is bootloader; after its done, second command has page 0x010; read_bank returns to 0 after two swaps.
- During a busy load, page_request 0x001 then 0x002 → request_dropped pulses once; next command has page 0x002.
- TIMEOUT_CYCLES = 8, no loader_done → timeout_error = 1 eight cycles after WAIT entry; read_bank and ready unchanged; the next request still issues normally.
- Assert reset 5 cycles into WAIT, then pulse loader_done → all outputs at reset values; no swap; loader_start stays 0.
- loader_done pulsed while IDLE → no state change, no bank toggle.
